buffet_fill_ctrl: RTL and testbench
===================================

Name: buffet_fill_ctrl

Overview:
Producer-side fill engine that drives the buffet Fill port and consumes the buffet credit stream. It takes a fill command (base address, length) and issues word read requests to upstream memory. A request is issued only when a buffet slot credit is held. Memory responses are forwarded in order to push_data, so the buffet can never overflow.

Parameters:
DATA_WIDTH, `DATA_WIDTH, data word width (matches buffet push_data)
IDX_WIDTH, `IDX_WIDTH, width of credit_in (matches buffet credit_out)
SIZE, `SIZE, buffet capacity in words; initial credit count
ADDR_WIDTH, 32, memory address width
LEN_WIDTH, 16, fill command length width (words)
ADDR_STRIDE, 1, address increment per word

Ports:
clk  input  1  clock
nreset_i  input  1  asynchronous active-low reset
cmd_base_addr  input  ADDR_WIDTH  first word address of fill
cmd_len  input  LEN_WIDTH  number of words to fill
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when valid&ready
mem_req_addr  output  ADDR_WIDTH  memory read address
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory request accepted
mem_resp_data  input  DATA_WIDTH  memory response data (in order)
mem_resp_valid  input  1  response valid
mem_resp_ready  output  1  response accepted
push_data  output  DATA_WIDTH  to buffet push_data
push_data_valid  output  1  to buffet push_data_valid
push_data_ready  input  1  from buffet push_data_ready
credit_in  input  IDX_WIDTH  credits returned by buffet (freed slots)
credit_valid  input  1  credit valid
credit_ready  output  1  credit accepted
busy  output  1  command in progress
done  output  1  one-cycle pulse: all words of command pushed
err  output  1  sticky protocol error

Behaviour:
- Reset (async, nreset_i low): state=IDLE; credits=SIZE; outstanding=0; remaining=0; addr=0; err=0. Outputs: cmd_ready=0 while nreset_i low, else per state. mem_req_valid=0, credit_ready=0 during reset, busy=0, done=0.
- Reset mid-command abandons it silently: no done, credits reload to SIZE. The buffet shares the reset.
- Credit counter: width IDX_WIDTH+1. credit_ready=1 whenever out of reset.
  - Each cycle: credits_next = credits + (credit_valid ? credit_in : 0) - (req handshake ? 1 : 0).
  - Simultaneous credit return and issue must both apply in the same cycle.
  - If credits_next > SIZE: err<=1 and credits saturate at SIZE.
- Outstanding counter: width IDX_WIDTH+1.
  - +1 on mem_req handshake; -1 on push handshake; both in one cycle leaves it unchanged.
  - A push handshake with outstanding==0 sets err<=1.
- Response path is combinational pass-through:
  - push_data=mem_resp_data; push_data_valid=mem_resp_valid; mem_resp_ready=push_data_ready.
  - Zero added latency; order preserved.
- FSM:
  - IDLE:
    - cmd_ready=1, busy=0.
    - On cmd handshake: latch addr=cmd_base_addr, remaining=cmd_len.
    - If cmd_len==0: done pulses next cycle, stay IDLE. Otherwise go to ISSUE.
  - ISSUE:
    - busy=1, cmd_ready=0, mem_req_addr=addr.
    - mem_req_valid = (credits!=0). It is combinational from registers only, never from mem_req_ready.
    - Once asserted, mem_req_valid/addr hold stable until handshake. Credits only increase in ISSUE, so this holds.
    - On handshake: addr+=ADDR_STRIDE (wraps modulo 2^ADDR_WIDTH), remaining-=1.
    - If remaining was 1 -> DRAIN.
  - DRAIN:
    - busy=1, mem_req_valid=0.
    - When outstanding==0, or when it becomes 0 via this cycle's push: done=1 for one cycle, -> IDLE.
- done is registered: asserted the cycle after the condition, exactly one cycle. A new command can be accepted in the cycle done is high.
- Credits and outstanding persist across commands. The next command may start issuing immediately with whatever credits remain.
- Invariant (verify by assertion): credits + outstanding + buffet occupancy == SIZE when no credit is in flight.
- Throughput: 1 request/cycle while credits>0 and mem_req_ready=1.

Test Plan:
- SIZE=8, cmd base=0x100 len=4, mem_req_ready=1, memory returns after 2 cycles -> requests 0x100..0x103 on 4 consecutive cycles; 4 pushes in order; credits=4; done pulses once; busy drops the same cycle done rises.
- SIZE=8, len=12, no credits returned -> exactly 8 requests, then mem_req_valid=0 stalls. Return credit_in=3 -> 3 more requests next cycles. Return 1 more -> final request, DRAIN, done after last push.
- Same cycle credit_valid with credit_in=2 and request handshake, credits=1 -> credits=2 next cycle.
- push_data_ready=0 for 5 cycles with responses pending -> mem_resp_ready=0; no data lost; push order matches addresses; outstanding holds.
- cmd_len=0 -> cmd accepted; no requests; done pulses the next cycle; busy stays 0.
- Assert nreset_i mid-ISSUE after 3 requests -> all outputs zero immediately; after release credits=8, state IDLE, no done. Credit return of 9 from reset -> err=1, credits=8.

Source files
------------

// File: rtl/buffet_fill_ctrl.sv
// rtl/buffet_fill_ctrl.sv - buffet fill engine: credit-gated word reads forwarded in order to push_data
module buffet_fill_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_WIDTH   = 4,
    parameter int SIZE        = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int ADDR_STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_data_valid,
    input  logic                  push_data_ready,
    input  logic [IDX_WIDTH-1:0]  credit_in,
    input  logic                  credit_valid,
    output logic                  credit_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CW = IDX_WIDTH + 1;
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic                  req_hs;
    logic                  push_hs;
    logic [SW-1:0]         credit_sum;

    assign mem_resp_ready  = push_data_ready;
    assign push_data       = mem_resp_data;
    assign push_data_valid = mem_resp_valid;
    assign credit_ready    = nreset_i;
    assign cmd_ready       = nreset_i && (state_q == S_IDLE);
    assign mem_req_addr    = addr_q;
    // Valid depends only on registers so it cannot drop while waiting for ready.
    assign mem_req_valid   = (state_q == S_ISSUE) && (credits_q != '0);
    assign req_hs          = mem_req_valid && mem_req_ready;
    assign push_hs         = mem_resp_valid && push_data_ready;
    assign done            = done_q;
    assign err             = err_q;

    always_comb begin
        err_d         = err_q;
        credits_d     = credits_q;
        outstanding_d = outstanding_q;
        credit_sum    = {1'b0, credits_q}
                      + (credit_valid ? SW'(credit_in) : '0)
                      - (req_hs ? SW'(1) : '0);
        if (credit_sum > SW'(SIZE)) begin
            err_d     = 1'b1;
            credits_d = CW'(SIZE);
        end else begin
            credits_d = credit_sum[CW-1:0];
        end
        if (push_hs && outstanding_q == '0) begin
            err_d = 1'b1;
        end
        case ({req_hs, push_hs})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = (outstanding_q == '0) ? '0 : outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        busy        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d      = cmd_base_addr;
                    remaining_d = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (req_hs) begin
                    addr_d      = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (outstanding_q == '0 || (outstanding_q == CW'(1) && push_hs)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q       <= S_IDLE;
            credits_q     <= CW'(SIZE);
            outstanding_q <= '0;
            remaining_q   <= '0;
            addr_q        <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            remaining_q   <= remaining_d;
            addr_q        <= addr_d;
            err_q         <= err_d;
            done_q        <= done_d;
        end
    end
endmodule

// File: tb/tb_buffet_fill_ctrl.sv
// tb/tb_buffet_fill_ctrl.sv - randomized bench for buffet_fill_ctrl against a word-level model
module tb_buffet_fill_ctrl;
    localparam int SIZE = 8;
    localparam int IDXW = 4;

    logic        clk = 1'b0;
    logic        nreset_i;
    logic [31:0] cmd_base_addr;
    logic [15:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_resp_data;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] push_data;
    logic        push_data_valid;
    logic        push_data_ready;
    logic [IDXW-1:0] credit_in;
    logic        credit_valid;
    logic        credit_ready;
    logic        busy;
    logic        done;
    logic        err;

    buffet_fill_ctrl #(.DATA_WIDTH(32), .IDX_WIDTH(IDXW), .SIZE(SIZE),
                       .ADDR_WIDTH(32), .LEN_WIDTH(16), .ADDR_STRIDE(1)) dut (
        .clk(clk), .nreset_i(nreset_i),
        .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .push_data(push_data), .push_data_valid(push_data_valid), .push_data_ready(push_data_ready),
        .credit_in(credit_in), .credit_valid(credit_valid), .credit_ready(credit_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Word-level model of the fill engine and its surroundings.
    bit          m_active;
    int          m_left;
    logic [31:0] m_addr;
    int          m_credits;
    int          m_out;
    bit          m_done;
    bit          m_err;
    logic [31:0] exp_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          occ, pend, cyc, nreq;
    bit          cmd_want, credits_on;
    int          pr_req, pr_push, force_cr;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        int k;
        cmd_valid       = cmd_want;
        mem_req_ready   = ($urandom_range(99) < pr_req);
        push_data_ready = ($urandom_range(99) < pr_push);
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mdata(mem_addr_q[0]);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        if (occ > 0 && $urandom_range(2) == 0) begin
            occ--;
            pend++;
        end
        if (force_cr > 0) begin
            credit_valid = 1'b1;
            credit_in    = IDXW'(force_cr);
            k = (force_cr < pend) ? force_cr : pend;
            pend -= k;
            occ  -= force_cr - k;
            force_cr = 0;
        end else if (credits_on && pend > 0 && $urandom_range(1) == 0) begin
            k = $urandom_range((pend < 15) ? pend : 15, 1);
            credit_valid = 1'b1;
            credit_in    = IDXW'(k);
            pend -= k;
        end else begin
            credit_valid = 1'b0;
            credit_in    = '0;
        end
    endtask

    task automatic step();
        bit exp_v, req_hs, push_hs, was_drain;
        int c;
        @(negedge clk);
        exp_v = m_active && m_left > 0 && m_credits > 0;
        check("busy", busy, m_active);
        check("cmd_ready", cmd_ready, !m_active);
        check("mem_req_valid", mem_req_valid, exp_v);
        check("done", done, m_done);
        check("err", err, m_err);
        check("credit_ready", credit_ready, 1);
        check("mem_resp_ready", mem_resp_ready, push_data_ready);
        check("push_valid", push_data_valid, mem_resp_valid);
        if (exp_v) check("req_addr", mem_req_addr, m_addr);
        req_hs  = exp_v && mem_req_ready;
        push_hs = mem_resp_valid && push_data_ready;
        if (push_hs) begin
            if (exp_q.size() == 0) check("push_unexpected", 1, 0);
            else check("push_data", push_data, mdata(exp_q.pop_front()));
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
            occ++;
        end
        if (req_hs) begin
            mem_addr_q.push_back(mem_req_addr);
            mem_due_q.push_back(cyc + 2);
            exp_q.push_back(m_addr);
            nreq++;
        end
        was_drain = m_active && m_left == 0;
        if (push_hs && m_out == 0) m_err = 1'b1;
        m_out = m_out + int'(req_hs) - int'(push_hs);
        if (m_out < 0) m_out = 0;
        c = m_credits + (credit_valid ? int'(credit_in) : 0) - int'(req_hs);
        if (c > SIZE) begin
            m_err = 1'b1;
            c = SIZE;
        end
        m_credits = c;
        m_done = 1'b0;
        if (cmd_valid && !m_active) begin
            cmd_want = 1'b0;
            if (cmd_len == 0) m_done = 1'b1;
            else begin
                m_active = 1'b1;
                m_left   = int'(cmd_len);
                m_addr   = cmd_base_addr;
            end
        end
        if (req_hs) begin
            m_addr = m_addr + 32'd1;
            m_left--;
        end
        if (was_drain && m_out == 0) begin
            m_done   = 1'b1;
            m_active = 1'b0;
        end
        if (!m_err) assert (m_credits + m_out + occ + pend == SIZE);
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic do_reset();
        nreset_i = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_credit_ready", credit_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        cmd_want = 0; cmd_valid = 0; cmd_base_addr = '0; cmd_len = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        push_data_ready = 0; credit_valid = 0; credit_in = '0; force_cr = 0;
        exp_q.delete(); mem_addr_q.delete(); mem_due_q.delete();
        occ = 0; pend = 0;
        m_active = 0; m_left = 0; m_addr = '0; m_credits = SIZE; m_out = 0; m_done = 0; m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset_i = 1'b1;
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic issue(input logic [31:0] base, input int len);
        cmd_base_addr = base;
        cmd_len       = 16'(len);
        cmd_want      = 1'b1;
        cmd_valid     = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        step();
        while ((m_active || cmd_want) && n < budget) begin
            step();
            n++;
        end
        if (m_active || cmd_want) check("idle_timeout", 0, 1);
    endtask

    initial begin
        cyc = 0; nreq = 0;
        pr_req = 100; pr_push = 100; credits_on = 0;
        do_reset();
        repeat (2) step();

        issue(32'h200, 0);
        repeat (3) step();

        issue(32'h100, 4);
        wait_idle(100);
        repeat (2) step();

        do_reset();
        nreq = 0;
        issue(32'h1000, 12);
        repeat (30) step();
        check("stall_at_8", nreq, 8);
        force_cr = 3;
        repeat (10) step();
        check("after_credit3", nreq, 11);
        force_cr = 1;
        wait_idle(100);
        check("after_credit1", nreq, 12);

        credits_on = 1;
        repeat (20) step();
        issue(32'h2000, 6);
        pr_push = 0;
        repeat (8) step();
        pr_push = 100;
        wait_idle(200);

        for (int i = 0; i < 40; i++) begin
            pr_req  = $urandom_range(100, 30);
            pr_push = $urandom_range(100, 30);
            issue(($urandom_range(3) == 0) ? 32'hFFFF_FFFA : $urandom, $urandom_range(20));
            wait_idle(1000);
            repeat ($urandom_range(3)) step();
        end

        pr_req = 100; pr_push = 100; credits_on = 0;
        do_reset();
        nreq = 0;
        issue(32'h300, 10);
        for (int n = 0; n < 50 && nreq < 3; n++) step();
        check("pre_reset_reqs", nreq, 3);
        do_reset();
        repeat (3) step();
        nreq = 0;
        issue(32'h400, 8);
        repeat (20) step();
        check("full_credits_after_reset", nreq, 8);

        do_reset();
        force_cr = 9;
        repeat (3) step();
        check("err_on_overflow", err, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
